// File: rtl/svpwm_pkg.sv
// Shared definitions for the SVPWM gate sequencer: gate codes, segment states
// and the sector-to-active-vector lookup.
package svpwm_pkg;

  localparam logic [5:0] GATE_ZERO = 6'b000000;
  localparam logic [5:0] GATE_V100 = 6'b000001;
  localparam logic [5:0] GATE_V110 = 6'b100000;
  localparam logic [5:0] GATE_V010 = 6'b000010;
  localparam logic [5:0] GATE_V011 = 6'b001000;
  localparam logic [5:0] GATE_V001 = 6'b000100;
  localparam logic [5:0] GATE_V101 = 6'b010000;

  typedef enum logic [2:0] {
    IDLE,
    ZERO_PRE,
    ACT1,
    ACT2,
    ZERO_POST
  } seg_state_t;

  typedef struct packed {
    logic [5:0] first;
    logic [5:0] second;
    logic       valid;
  } sector_vec_t;

  function automatic sector_vec_t sector_vectors(input logic [2:0] sector);
    sector_vec_t v;
    case (sector)
      3'd0:    v = '{GATE_V100, GATE_V110, 1'b1};
      3'd1:    v = '{GATE_V110, GATE_V010, 1'b1};
      3'd2:    v = '{GATE_V010, GATE_V011, 1'b1};
      3'd3:    v = '{GATE_V011, GATE_V001, 1'b1};
      3'd4:    v = '{GATE_V001, GATE_V101, 1'b1};
      3'd5:    v = '{GATE_V101, GATE_V100, 1'b1};
      default: v = '{GATE_ZERO, GATE_ZERO, 1'b0};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/svpwm_gate_sequencer_counter.sv
// Period counter: counts 0..P-1, holds at 0 while disabled or P=0, and flags
// the boundary (start_o) whenever the next cycle opens a new period.
module pwm_period_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 running_i,
  input  logic [CNT_WIDTH-1:0] next_period_i,
  output logic [CNT_WIDTH-1:0] cnt_d_o,
  output logic                 run_d_o,
  output logic                 start_o
);

  logic [CNT_WIDTH-1:0] cnt_q, per_q, per_d;
  logic                 last;

  always_comb begin
    last    = running_i && (cnt_q == per_q - 1'b1);
    cnt_d_o = cnt_q + 1'b1;
    per_d   = per_q;
    run_d_o = running_i;
    start_o = 1'b0;
    if (!en_i) begin
      cnt_d_o = '0;
      run_d_o = 1'b0;
    end else if (!running_i || last) begin
      // Idle re-polls the shadow period every cycle; a wrap with P=0 drops to idle.
      cnt_d_o = '0;
      run_d_o = (next_period_i != '0);
      start_o = run_d_o;
      if (run_d_o) per_d = next_period_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      per_q <= '0;
    end else begin
      cnt_q <= cnt_d_o;
      per_q <= per_d;
    end
  end

endmodule

// File: rtl/svpwm_gate_sequencer.sv
// SVPWM gate sequencer: shadowed command, per-period clamp and segment FSM,
// registered one-hot gate output. Macro SVPWM_ALTERNATE_EN reverses the
// active-vector order on odd periods.
module svpwm_gate_sequencer
  import svpwm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_sector,
  input  logic [CNT_WIDTH-1:0] cmd_t1,
  input  logic [CNT_WIDTH-1:0] cmd_t2,
  input  logic [CNT_WIDTH-1:0] cmd_period,
  output logic [5:0]           gates,
  output logic                 period_start,
  output logic                 sat,
  output logic                 sector_err
);

  logic [2:0]           sh_sector_q, sh_sector_d;
  logic [CNT_WIDTH-1:0] sh_t1_q, sh_t1_d, sh_t2_q, sh_t2_d, sh_per_q, sh_per_d;
  seg_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] b1_q, b2_q, b3_q, b1_n, b2_n, b3_n, b1, b2, b3;
  logic [5:0]           lead_q, lag_q, lead_n, lag_n, lead, lag, gates_d;
  logic [CNT_WIDTH-1:0] t1c, t2c, rem, t0, pre, lead_len;
  logic                 sat_n, err_sel, sat_sel, odd;
  sector_vec_t          sv;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 run_d, start;

  assign cmd_ready = 1'b1;

  pwm_period_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .running_i    (state_q != IDLE),
    .next_period_i(sh_per_d),
    .cnt_d_o      (cnt_d),
    .run_d_o      (run_d),
    .start_o      (start)
  );

`ifdef SVPWM_ALTERNATE_EN
  logic par_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        par_q <= 1'b0;
    else if (!en)   par_q <= 1'b0;
    else if (start) par_q <= ~par_q;
  end
  assign odd = par_q;
`else
  assign odd = 1'b0;
`endif

  always_comb begin
    sh_sector_d = cmd_valid ? cmd_sector : sh_sector_q;
    sh_t1_d     = cmd_valid ? cmd_t1     : sh_t1_q;
    sh_t2_d     = cmd_valid ? cmd_t2     : sh_t2_q;
    sh_per_d    = cmd_valid ? cmd_period : sh_per_q;

    // rem = P - t1c, so t1c + t2c never exceeds P and t0 cannot underflow.
    t1c   = (sh_t1_d > sh_per_d) ? sh_per_d : sh_t1_d;
    rem   = sh_per_d - t1c;
    t2c   = (sh_t2_d > rem) ? rem : sh_t2_d;
    sat_n = (sh_t1_d > sh_per_d) || (sh_t2_d > rem);
    t0    = rem - t2c;
    pre   = t0 >> 1;

    sv       = sector_vectors(sh_sector_d);
    lead_n   = odd ? sv.second : sv.first;
    lag_n    = odd ? sv.first  : sv.second;
    lead_len = odd ? t2c : t1c;
    b1_n     = pre;
    b2_n     = pre + lead_len;
    b3_n     = pre + t1c + t2c;

    b1      = start ? b1_n   : b1_q;
    b2      = start ? b2_n   : b2_q;
    b3      = start ? b3_n   : b3_q;
    lead    = start ? lead_n : lead_q;
    lag     = start ? lag_n  : lag_q;
    err_sel = start ? !sv.valid : sector_err;
    sat_sel = start ? sat_n     : sat;

    // Segment is a pure function of the next count, so empty segments vanish.
    if (!run_d)        state_d = IDLE;
    else if (cnt_d < b1) state_d = ZERO_PRE;
    else if (cnt_d < b2) state_d = ACT1;
    else if (cnt_d < b3) state_d = ACT2;
    else                 state_d = ZERO_POST;

    case (state_d)
      ACT1:    gates_d = lead;
      ACT2:    gates_d = lag;
      default: gates_d = GATE_ZERO;
    endcase
    if (err_sel) gates_d = GATE_ZERO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_sector_q  <= '0;
      sh_t1_q      <= '0;
      sh_t2_q      <= '0;
      sh_per_q     <= '0;
      state_q      <= IDLE;
      b1_q         <= '0;
      b2_q         <= '0;
      b3_q         <= '0;
      lead_q       <= GATE_ZERO;
      lag_q        <= GATE_ZERO;
      gates        <= GATE_ZERO;
      period_start <= 1'b0;
      sat          <= 1'b0;
      sector_err   <= 1'b0;
    end else begin
      sh_sector_q  <= sh_sector_d;
      sh_t1_q      <= sh_t1_d;
      sh_t2_q      <= sh_t2_d;
      sh_per_q     <= sh_per_d;
      state_q      <= state_d;
      gates        <= gates_d;
      period_start <= start;
      sat          <= run_d && sat_sel;
      sector_err   <= run_d && err_sel;
      if (start) begin
        b1_q   <= b1_n;
        b2_q   <= b2_n;
        b3_q   <= b3_n;
        lead_q <= lead_n;
        lag_q  <= lag_n;
      end
    end
  end

endmodule

// File: tb/tb_svpwm_gate_sequencer.sv
// Directed self-checking bench for svpwm_gate_sequencer (both SVPWM_ALTERNATE_EN builds).
module tb_svpwm_gate_sequencer;

  localparam int W = 16;
`ifdef SVPWM_ALTERNATE_EN
  localparam bit ALT = 1'b1;
`else
  localparam bit ALT = 1'b0;
`endif

  localparam logic [5:0] V100 = 6'b000001, V110 = 6'b100000, V010 = 6'b000010;
  localparam logic [5:0] V011 = 6'b001000, V001 = 6'b000100, V101 = 6'b010000;

  logic         clk = 1'b0;
  logic         rst, en, cmd_valid, cmd_ready;
  logic [2:0]   cmd_sector;
  logic [W-1:0] cmd_t1, cmd_t2, cmd_period;
  logic [5:0]   gates, exp_g;
  logic         period_start, sat, sector_err;
  int           checks = 0, failures = 0;
  bit           par = 1'b0, odd = 1'b0;

  always #5 clk = ~clk;

  svpwm_gate_sequencer #(.CNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sector(cmd_sector), .cmd_t1(cmd_t1), .cmd_t2(cmd_t2), .cmd_period(cmd_period),
    .gates(gates), .period_start(period_start), .sat(sat), .sector_err(sector_err)
  );

  // Reference gate value at cycle c of a period (pre/t1c/t2c hand-computed by callers).
  function automatic logic [5:0] model(input int c, pre, t1c, t2c,
                                       input logic [5:0] f, s, input bit o, err);
    int la;
    la = o ? t2c : t1c;
    if (err)                   return 6'b000000;
    if (c < pre)               return 6'b000000;
    if (c < pre + la)          return o ? s : f;
    if (c < pre + t1c + t2c)   return o ? f : s;
    return 6'b000000;
  endfunction

  task automatic set_cmd(input logic [2:0] s, input int t1, t2, p);
    cmd_valid  = 1'b1;
    cmd_sector = s;
    cmd_t1     = W'(t1);
    cmd_t2     = W'(t2);
    cmd_period = W'(p);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; cmd_valid = 1'b0;
    cmd_sector = '0; cmd_t1 = '0; cmd_t2 = '0; cmd_period = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (gates !== 6'b0) begin failures++; $display("FAIL reset_gates got=%b exp=000000", gates); end
    checks++; if (period_start !== 1'b0) begin failures++; $display("FAIL reset_pstart got=%b exp=0", period_start); end
    checks++; if (sat !== 1'b0 || sector_err !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", sat, sector_err); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    rst = 1'b0; par = 1'b0;
    @(posedge clk); #1;
    checks++; if (gates !== 6'b0 || period_start !== 1'b0) begin failures++; $display("FAIL idle_disabled got=%b/%b exp=000000/0", gates, period_start); end
  endtask

  // P=100 s0 t1=30 t2=20: t0=50 pre=25; two periods.
  task automatic test_basic;
    set_cmd(3'd0, 30, 20, 100); en = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (c % 100 == 0) begin odd = ALT && par; par = !par; end
      exp_g = model(c % 100, 25, 30, 20, V100, V110, odd, 1'b0);
      checks++; if (gates !== exp_g) begin failures++; $display("FAIL basic_gates c=%0d got=%b exp=%b", c, gates, exp_g); end
      checks++; if (period_start !== (c % 100 == 0)) begin failures++; $display("FAIL basic_pstart c=%0d got=%b", c, period_start); end
      checks++; if (sat !== 1'b0 || sector_err !== 1'b0) begin failures++; $display("FAIL basic_flags c=%0d got=%b%b exp=00", c, sat, sector_err); end
    end
  endtask

  // P=10 s3 t1=8 t2=6: t1c=8 t2c=2 pre=post=0, sat.
  task automatic test_clamp;
    set_cmd(3'd3, 8, 6, 10);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c % 10 == 0) begin odd = ALT && par; par = !par; end
      exp_g = model(c % 10, 0, 8, 2, V011, V001, odd, 1'b0);
      checks++; if (gates !== exp_g) begin failures++; $display("FAIL clamp_gates c=%0d got=%b exp=%b", c, gates, exp_g); end
      checks++; if (sat !== 1'b1) begin failures++; $display("FAIL clamp_sat c=%0d got=%b exp=1", c, sat); end
      checks++; if (period_start !== (c % 10 == 0)) begin failures++; $display("FAIL clamp_pstart c=%0d got=%b", c, period_start); end
    end
  endtask

  // Sector 6 then sector 2, P=20 t1=5 t2=5: pre=5.
  task automatic test_invalid;
    set_cmd(3'd6, 5, 5, 20);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (c % 20 == 0) begin odd = ALT && par; par = !par; end
      exp_g = model(c % 20, 5, 5, 5, V010, V011, odd, c < 20);
      checks++; if (gates !== exp_g) begin failures++; $display("FAIL invalid_gates c=%0d got=%b exp=%b", c, gates, exp_g); end
      checks++; if (sector_err !== (c < 20)) begin failures++; $display("FAIL invalid_err c=%0d got=%b exp=%b", c, sector_err, c < 20); end
      checks++; if (sat !== 1'b0) begin failures++; $display("FAIL invalid_sat c=%0d got=%b exp=0", c, sat); end
      if (c == 19) cmd_sector = 3'd2;
    end
  endtask

  // P=20 t1=6 t2=4 (pre=5); sector 0 -> 4 beat mid-period, later garbage ignored.
  task automatic test_midchange;
    set_cmd(3'd0, 6, 4, 20);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (c % 20 == 0) begin odd = ALT && par; par = !par; end
      exp_g = (c < 20) ? model(c, 5, 6, 4, V100, V110, odd, 1'b0)
                       : model(c - 20, 5, 6, 4, V001, V101, odd, 1'b0);
      checks++; if (gates !== exp_g) begin failures++; $display("FAIL midchg_gates c=%0d got=%b exp=%b", c, gates, exp_g); end
      checks++; if (period_start !== (c % 20 == 0)) begin failures++; $display("FAIL midchg_pstart c=%0d got=%b", c, period_start); end
      if (c == 0) cmd_valid = 1'b0;
      if (c == 8) begin cmd_sector = 3'd4; cmd_valid = 1'b1; end
      if (c == 9) begin cmd_sector = 3'd5; cmd_valid = 1'b0; end
    end
  endtask

  task automatic test_p0_p1;
    set_cmd(3'd0, 1, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++; if (gates !== 6'b0 || period_start !== 1'b0) begin failures++; $display("FAIL p0_idle c=%0d got=%b/%b exp=000000/0", c, gates, period_start); end
    end
    cmd_period = W'(1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      odd = ALT && par; par = !par;
      checks++; if (gates !== V100) begin failures++; $display("FAIL p1_gates c=%0d got=%b exp=%b", c, gates, V100); end
      checks++; if (period_start !== 1'b1) begin failures++; $display("FAIL p1_pstart c=%0d got=%b exp=1", c, period_start); end
    end
    cmd_t1 = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      odd = ALT && par; par = !par;
      checks++; if (gates !== 6'b0 || period_start !== 1'b1) begin failures++; $display("FAIL p1_zero c=%0d got=%b/%b exp=000000/1", c, gates, period_start); end
    end
  endtask

  // P=20 s0 t1=6 t2=4 (pre=5): en drop in ACT1, then async reset in ACT2.
  task automatic test_en_rst;
    set_cmd(3'd0, 6, 4, 20);
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin odd = ALT && par; par = !par; end
      exp_g = model(c, 5, 6, 4, V100, V110, odd, 1'b0);
      checks++; if (gates !== exp_g) begin failures++; $display("FAIL en_pre c=%0d got=%b exp=%b", c, gates, exp_g); end
    end
    en = 1'b0; par = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (gates !== 6'b0 || period_start !== 1'b0) begin failures++; $display("FAIL en_low c=%0d got=%b/%b exp=000000/0", c, gates, period_start); end
    end
    en = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin odd = ALT && par; par = !par; end
      exp_g = model(c, 5, 6, 4, V100, V110, odd, 1'b0);
      checks++; if (gates !== exp_g) begin failures++; $display("FAIL en_rise_gates c=%0d got=%b exp=%b", c, gates, exp_g); end
      checks++; if (period_start !== (c == 0)) begin failures++; $display("FAIL en_rise_pstart c=%0d got=%b", c, period_start); end
    end
    #1 rst = 1'b1;
    #1;
    checks++; if (gates !== 6'b0 || period_start !== 1'b0 || sat !== 1'b0 || sector_err !== 1'b0)
      begin failures++; $display("FAIL rst_async got=%b/%b%b%b exp=000000/000", gates, period_start, sat, sector_err); end
    #1 rst = 1'b0; par = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin odd = ALT && par; par = !par; end
      exp_g = model(c, 5, 6, 4, V100, V110, odd, 1'b0);
      checks++; if (gates !== exp_g) begin failures++; $display("FAIL rst_rel_gates c=%0d got=%b exp=%b", c, gates, exp_g); end
      checks++; if (period_start !== (c == 0)) begin failures++; $display("FAIL rst_rel_pstart c=%0d got=%b", c, period_start); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_invalid();
    test_midchange();
    test_p0_p1();
    test_en_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
